// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and BCD constants for the binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [3:0] BCD_BLANK      = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 when the digit is 5 or more
//   din  [3:0] scratch BCD digit before the shift
//   dout [3:0] corrected digit (4-bit wrap, no carry out)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb dout = din >= BCD_ADJ_THRESH ? din + 4'd3 : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter feeding seven-segment decoders
//   clk, rst            clock, synchronous active-high reset
//   start, value        conversion request (taken in IDLE) and WIDTH-bit operand
//   busy, done          conversion in progress, one-cycle result strobe
//   bcd, overflow       DIGITS BCD codes (digit 0 = ones), value too large flag
//   Optional macro BCD_LEADING_BLANK_EN: leading zero digits above digit 0 become 4'hF.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  state_t state, state_n;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0] scratch, adj, fin_bcd;
  logic [CW-1:0] cnt;
  logic sticky, cap, shift_en, fin, last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.din(scratch[4*i +: 4]), .dout(adj[4*i +: 4]));
  end
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE  ? (start ? SHIFT : IDLE) :
              state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    cap      = state == IDLE && start;
    shift_en = state == SHIFT;
    fin      = state == DONE;
  end
`ifdef BCD_LEADING_BLANK_EN
  logic seen;
  always_comb begin
    fin_bcd = scratch;
    seen    = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen = seen | (scratch[4*i +: 4] != 4'd0);
      fin_bcd[4*i +: 4] = seen ? scratch[4*i +: 4] : BCD_BLANK;
    end
  end
`else
  always_comb fin_bcd = scratch;
`endif
  // The bit leaving the top digit after correction marks a value beyond DIGITS decimal digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= fin;
      if (cap) begin
        bin     <= value;
        scratch <= '0;
        cnt     <= '0;
        sticky  <= 1'b0;
      end
      if (shift_en) begin
        scratch <= {adj[BW-2:0], bin[WIDTH-1]};
        bin     <= bin << 1;
        cnt     <= cnt + 1'b1;
        sticky  <= sticky | adj[BW-1];
      end
      if (fin) begin
        bcd      <= sticky ? {DIGITS{BCD_BLANK}} : fin_bcd;
        overflow <= sticky;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: self-checking bench for bin_to_bcd_seq (defaults and a 4-digit instance)
module tb_bin_to_bcd_seq;
`ifdef BCD_LEADING_BLANK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  typedef struct {logic [19:0] bcd; logic ovf; int k;} exp_t;
  typedef struct {logic [15:0] v; logic [19:0] bcd; logic ovf;} vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start4 = 1'b0;
  logic [15:0] value = '0, value4 = '0;
  logic busy, done, overflow, busy4, done4, overflow4;
  logic [19:0] bcd;
  logic [15:0] bcd4;
  int cyc = 0, tests = 0, fails = 0;
  exp_t q[$];
  vec_t vec[7];
  bin_to_bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .value(value4),
    .busy(busy4), .done(done4), .bcd(bcd4), .overflow(overflow4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [19:0] mdl(input int v, input int d);
    logic [19:0] r = '0;
    int x = v;
    bit nz = 1'b0;
    if (v >= 10 ** d) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'hF;
      return r;
    end
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (LB)
      for (int i = d - 1; i > 0; i--) begin
        nz = nz | (r[4*i +: 4] != 4'd0);
        if (!nz) r[4*i +: 4] = 4'hF;
      end
    return r;
  endfunction
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 with bcd=%h expected no done (cycle %0d)", bcd, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd", 32'(bcd), 32'(e.bcd));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("latency", 32'(cyc - e.k), 32'd17);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask
  task automatic run(input logic [15:0] v, input logic [19:0] eb, input logic eo);
    @(posedge clk); #1;
    start = 1'b1;
    value = v;
    q.push_back('{bcd: eb, ovf: eo, k: cyc + 1});
    @(posedge clk); #1;
    start = 1'b0;
    value = 16'($urandom);
    drain();
  endtask
  task automatic run4(input logic [15:0] v, input logic [15:0] eb, input logic eo);
    int k, n;
    @(posedge clk); #1;
    start4 = 1'b1;
    value4 = v;
    k = cyc + 1;
    @(posedge clk); #1;
    start4 = 1'b0;
    value4 = 16'($urandom);
    n = 0;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done4_seen", 32'(done4), 32'd1);
    chk("bcd4", 32'(bcd4), 32'(eb));
    chk("overflow4", 32'(overflow4), 32'(eo));
    chk("latency4", 32'(cyc - k), 32'd17);
  endtask
  initial begin
    vec[0] = '{16'd0,     LB ? 20'hFFFF0 : 20'h00000, 1'b0};
    vec[1] = '{16'd12345, 20'h12345,                  1'b0};
    vec[2] = '{16'd65535, 20'h65535,                  1'b0};
    vec[3] = '{16'd9,     LB ? 20'hFFFF9 : 20'h00009, 1'b0};
    vec[4] = '{16'd100,   LB ? 20'hFF100 : 20'h00100, 1'b0};
    vec[5] = '{16'd40000, 20'h40000,                  1'b0};
    vec[6] = '{16'd1000,  LB ? 20'hF1000 : 20'h01000, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) run(vec[i].v, vec[i].bcd, vec[i].ovf);
    // starts during SHIFT, plus operand changes after capture, must not disturb the result
    @(posedge clk); #1;
    start = 1'b1;
    value = 16'd12345;
    q.push_back('{bcd: 20'h12345, ovf: 1'b0, k: cyc + 1});
    @(posedge clk); #1;
    start = 1'b0;
    value = 16'd999;
    @(negedge clk);
    chk("busy_after_start", 32'(busy), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b1;
      value = 16'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
    end
    drain();
    repeat (25) @(negedge clk);
    chk("idle_after_ignore", 32'(busy), 32'd0);
    // reset on cycle 8 of a conversion aborts it
    @(posedge clk); #1;
    start = 1'b1;
    value = 16'd42;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    repeat (20) @(negedge clk);
    run(16'd42, LB ? 20'hFFF42 : 20'h00042, 1'b0);
    // start held high: one capture every 18 cycles with whatever value is present
    @(posedge clk); #1;
    start = 1'b1;
    for (int j = 0; j < 72; j++) begin
      if (j != 0) begin
        @(posedge clk); #1;
      end
      value = 16'($urandom);
      if (j % 18 == 0) q.push_back('{bcd: mdl(int'(value), 5), ovf: 1'b0, k: cyc + 1});
    end
    start = 1'b0;
    drain();
    repeat (20) @(negedge clk);
    run4(16'd12345, 16'hFFFF, 1'b1);
    run4(16'd9999,  16'h9999, 1'b0);
    run4(16'd10000, 16'hFFFF, 1'b1);
    run4(16'd7, LB ? 16'hFFF7 : 16'h0007, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
